// File: rtl/bch_encoder.sv
// BCH(15,7) t=2 systematic encoder, g(x) = x^8+x^7+x^6+x^4+1.
// Divides the message by g(x) with an 8-bit LFSR, then shifts the codeword out serially.
module bch_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  msg,
    output logic        busy,
    output logic [14:0] codeword,
    output logic        sout,
    output logic        sout_valid,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        SER  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Low-order taps of g(x): x^7 + x^6 + x^4 + 1 (x^8 term is implied by the shift-out).
    localparam logic [7:0] G_TAPS = 8'b1101_0001;

    state_t      state_r;
    logic [6:0]  msg_r;
    logic [7:0]  lfsr_r;
    logic [3:0]  cnt_r;
    logic [7:0]  lfsr_next_s;
    logic [14:0] cw_next_s;

    function automatic logic [7:0] lfsr_step(input logic [7:0] r, input logic din);
        logic fb;
        fb = din ^ r[7];
        return {r[6:0], 1'b0} ^ ({8{fb}} & G_TAPS);
    endfunction

    // Next remainder and the codeword that would be loaded if this were the last ENC cycle.
    always_comb begin
        lfsr_next_s = lfsr_step(lfsr_r, msg_r[cnt_r[2:0]]);
        cw_next_s   = 15'h0000;
        cw_next_s[6:0] = msg_r;
        for (int k = 0; k < 8; k++) begin
            cw_next_s[7 + k] = lfsr_next_s[7 - k];
        end
    end

    // Control FSM, parity LFSR, codeword register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            msg_r      <= 7'h00;
            lfsr_r     <= 8'h00;
            cnt_r      <= 4'd0;
            codeword   <= 15'h0000;
            busy       <= 1'b0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done       <= 1'b0;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    if (start) begin
                        msg_r   <= msg;
                        lfsr_r  <= 8'h00;
                        cnt_r   <= 4'd0;
                        busy    <= 1'b1;
                        state_r <= ENC;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ENC: begin
                    lfsr_r <= lfsr_next_s;
                    if (cnt_r == 4'd6) begin
                        codeword   <= cw_next_s;
                        sout       <= cw_next_s[0];
                        sout_valid <= 1'b1;
                        cnt_r      <= 4'd0;
                        state_r    <= SER;
                    end else begin
                        cnt_r      <= cnt_r + 4'd1;
                    end
                end
                SER: begin
                    if (cnt_r == 4'd14) begin
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        done       <= 1'b1;
                        cnt_r      <= 4'd0;
                        state_r    <= FIN;
                    end else begin
                        // sout already shows codeword[cnt_r]; present the next bit.
                        sout       <= codeword[cnt_r + 4'd1];
                        cnt_r      <= cnt_r + 4'd1;
                    end
                end
                FIN: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    busy       <= 1'b0;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    done       <= 1'b0;
                    cnt_r      <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bch_encoder.sv
// Self-checking bench for bch_encoder: polynomial-division reference model, cycle-exact
// output expectations, and a brute-force t=2 decoder to confirm codewords are correctable.
module tb_bch_encoder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [6:0]  msg;
    logic        busy;
    logic [14:0] codeword;
    logic        sout;
    logic        sout_valid;
    logic        done;

    int          vectors;
    int          miscompares;
    logic [14:0] prev_cw;

    bch_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .msg        (msg),
        .busy       (busy),
        .codeword   (codeword),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remainder of the word (bit j = coefficient of x^(14-j)) divided by g(x).
    function automatic logic [7:0] syndrome(input logic [14:0] w);
        logic [14:0] p;
        logic [14:0] g;
        p = 15'h0000;
        g = 15'h01D1;
        for (int j = 0; j < 15; j++) p[14 - j] = w[j];
        for (int i = 14; i >= 8; i--) begin
            if (p[i]) p = p ^ (g << (i - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [14:0] enc_model(input logic [6:0] m);
        logic [7:0]  rem;
        logic [14:0] cw;
        rem = syndrome({8'h00, m});
        cw  = {8'h00, m};
        for (int j = 7; j < 15; j++) cw[j] = rem[14 - j];
        return cw;
    endfunction

    task automatic decode(input logic [14:0] r, output logic [14:0] corr, output int nerr);
        logic [14:0] e;
        corr = r;
        nerr = 3;
        if (syndrome(r) == 8'h00) begin
            nerr = 0;
        end else begin
            for (int i = 0; i < 15 && nerr == 3; i++) begin
                e = 15'h0001 << i;
                if (syndrome(r ^ e) == 8'h00) begin corr = r ^ e; nerr = 1; end
            end
            for (int i = 0; i < 15 && nerr == 3; i++) begin
                for (int k = i + 1; k < 15 && nerr == 3; k++) begin
                    e = (15'h0001 << i) | (15'h0001 << k);
                    if (syndrome(r ^ e) == 8'h00) begin corr = r ^ e; nerr = 2; end
                end
            end
        end
    endtask

    // One full encode from the E0 edge to E23, checking every cycle. With hold=1 start stays
    // high and msg keeps changing; otherwise start toggles randomly while busy.
    task automatic run_encode(input logic [6:0] m, input bit hold, input string name,
                              output logic [14:0] got);
        logic [14:0] cw;
        logic [18:0] exp_v;
        logic [18:0] obs_v;
        cw = enc_model(m);
        @(negedge clk);
        start = 1'b1;
        msg   = m;
        for (int e = 0; e < 24; e++) begin
            @(posedge clk);
            #1;
            if (e < 7)       exp_v = {1'b1, 1'b0, 1'b0, 1'b0, prev_cw};
            else if (e < 22) exp_v = {1'b1, 1'b1, cw[e - 7], 1'b0, cw};
            else if (e == 22) exp_v = {1'b1, 1'b0, 1'b0, 1'b1, cw};
            else             exp_v = {1'b0, 1'b0, 1'b0, 1'b0, cw};
            obs_v = {busy, sout_valid, sout, done, codeword};
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL %s msg=%h E%0d: busy/valid/sout/done/cw got %b expected %b",
                         name, m, e, obs_v, exp_v);
            end
            msg = 7'($urandom);
            if (hold) start = 1'b1;
            else      start = (e < 21) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        got     = codeword;
        prev_cw = cw;
    endtask

    task automatic test_reset();
        logic [18:0] obs_v;
        rst_n = 1'b0;
        start = 1'b0;
        msg   = 7'h00;
        #3;
        obs_v = {busy, sout_valid, sout, done, codeword};
        vectors++;
        if (obs_v !== 19'h0) begin
            miscompares++;
            $display("FAIL reset_async: outputs got %b expected 0", obs_v);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            obs_v = {busy, sout_valid, sout, done, codeword};
            vectors++;
            if (obs_v !== 19'h0) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: outputs got %b expected 0", i, obs_v);
            end
        end
        prev_cw = 15'h0000;
    endtask

    task automatic test_known();
        logic [14:0] got;
        logic [6:0]  ms [4];
        logic [14:0] cs [4];
        ms = '{7'h00, 7'h40, 7'h17, 7'h7F};
        cs = '{15'h0000, 15'h45C0, 15'h0117, 15'h7FFF};
        for (int i = 0; i < 4; i++) begin
            run_encode(ms[i], 1'b0, "known", got);
            vectors++;
            if (got !== cs[i]) begin
                miscompares++;
                $display("FAIL known_cw msg=%h: got %h expected %h", ms[i], got, cs[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] got;
        for (int i = 0; i < 4; i++) begin
            run_encode(7'($urandom), 1'b1, "back_to_back", got);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        vectors++;
        if ({busy, sout_valid, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL back_to_back_idle: busy/valid/done got %b expected 000",
                     {busy, sout_valid, done});
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] got;
        logic [18:0] obs_v;
        @(negedge clk);
        start = 1'b1;
        msg   = 7'h2B;
        for (int e = 0; e <= 12; e++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        obs_v = {busy, sout_valid, sout, done, codeword};
        vectors++;
        if (obs_v !== 19'h0) begin
            miscompares++;
            $display("FAIL reset_mid_async: outputs got %b expected 0", obs_v);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        prev_cw = 15'h0000;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            obs_v = {busy, sout_valid, sout, done, codeword};
            vectors++;
            if (obs_v !== 19'h0) begin
                miscompares++;
                $display("FAIL reset_mid_quiet cycle %0d: outputs got %b expected 0", i, obs_v);
            end
        end
        run_encode(7'h40, 1'b0, "after_reset", got);
        vectors++;
        if (got !== 15'h45C0) begin
            miscompares++;
            $display("FAIL after_reset_cw: got %h expected 45c0", got);
        end
    endtask

    task automatic test_random();
        logic [14:0] got;
        logic [14:0] exp_cw;
        logic [14:0] corr;
        logic [14:0] bad;
        logic [6:0]  m;
        int          nerr;
        int          p0;
        int          p1;
        for (int n = 0; n < 1000; n++) begin
            m      = 7'($urandom);
            exp_cw = enc_model(m);
            run_encode(m, 1'b0, "random", got);
            decode(got, corr, nerr);
            vectors++;
            if (syndrome(got) !== 8'h00 || nerr != 0) begin
                miscompares++;
                $display("FAIL random_syndrome msg=%h: cw %h syndrome %h nerr %0d expected 0",
                         m, got, syndrome(got), nerr);
            end
            p0  = $urandom_range(0, 14);
            p1  = (p0 + $urandom_range(1, 14)) % 15;
            bad = got ^ (15'h0001 << p0);
            if (n % 2 == 1) bad = bad ^ (15'h0001 << p1);
            decode(bad, corr, nerr);
            vectors++;
            if (corr !== exp_cw || nerr != (n % 2) + 1) begin
                miscompares++;
                $display("FAIL random_correct msg=%h: corrected %h nerr %0d expected %h nerr %0d",
                         m, corr, nerr, exp_cw, (n % 2) + 1);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        prev_cw     = 15'h0000;
        test_reset();
        test_known();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
